// File: rtl/q_sweep_sequencer_if.sv
// Result stream between the sweep sequencer and its consumer.
//   result_valid   : result available (master -> slave)
//   result_ready   : consumer accepts result (slave -> master)
//   result_i_ref   : captured controller i_ref
//   result_q       : captured measured_q
//   result_index   : setpoint index of the result
//   result_timeout : point ended by timeout rather than convergence
interface q_sweep_sequencer_if #(
   parameter int WIDTH = 10,
   parameter int IDX_W = 4
);
   logic             result_valid;
   logic             result_ready;
   logic [WIDTH-1:0] result_i_ref;
   logic [WIDTH-1:0] result_q;
   logic [IDX_W-1:0] result_index;
   logic             result_timeout;

   modport master (
      output result_valid, result_i_ref, result_q, result_index, result_timeout,
      input  result_ready
   );

   modport slave (
      input  result_valid, result_i_ref, result_q, result_index, result_timeout,
      output result_ready
   );
endinterface

// File: rtl/q_sweep_sequencer.sv
// Steps the i_ref controller through a sweep of desired_q setpoints. Each
// point: reset the controller, hold it for SETTLE cycles, enable it until it
// converges or TIMEOUT cycles elapse, then offer the final i_ref/measured_q
// pair on the result stream.
//   clk, rst        : clock, synchronous active-high reset
//   start, abort    : begin sweep (IDLE only) / terminate sweep (non-IDLE)
//   busy, done      : sweep in progress / one-cycle pulse on final handshake
//   ctrl_rst        : controller reset
//   ctrl_ready      : controller enable
//   desired_q       : current setpoint
//   ctrl_converged, ctrl_i_ref, measured_q : controller / plant observations
//   res             : result stream (master side)
module q_sweep_sequencer #(
   parameter int WIDTH    = 10,
   parameter int N_POINTS = 14,
   parameter int Q_START  = 30,
   parameter int Q_STEP   = 20,
   parameter int SETTLE   = 2,
   parameter int TIMEOUT  = 64,
   parameter int IDX_W    = (N_POINTS > 1) ? $clog2(N_POINTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 ctrl_rst,
   output logic                 ctrl_ready,
   output logic [WIDTH-1:0]     desired_q,
   input  logic                 ctrl_converged,
   input  logic [WIDTH-1:0]     ctrl_i_ref,
   input  logic [WIDTH-1:0]     measured_q,
   q_sweep_sequencer_if.master  res
);

   localparam longint Q_MAX = (longint'(1) << WIDTH) - 1;
   localparam logic [WIDTH-1:0] Q_START_SAT =
      (longint'(Q_START) > Q_MAX) ? '1 : WIDTH'(Q_START);
   localparam logic [WIDTH:0] STEP_EXT =
      (longint'(Q_STEP) > Q_MAX) ? {1'b0, {WIDTH{1'b1}}} : (WIDTH+1)'(Q_STEP);
   // One counter serves both SETTLE and RUN; it is cleared on each entry.
   localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_POINTS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET_CTRL,
      S_SETTLE,
      S_RUN,
      S_REPORT
   } state_t;

   state_t           state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] dq, dq_n;
   logic             done_r, done_n;
   logic [WIDTH-1:0] ri, ri_n, rq, rq_n;
   logic             rto, rto_n;
   logic [WIDTH:0]   dq_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         idx    <= '0;
         cnt    <= '0;
         dq     <= Q_START_SAT;
         done_r <= 1'b0;
         ri     <= '0;
         rq     <= '0;
         rto    <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         cnt    <= cnt_n;
         dq     <= dq_n;
         done_r <= done_n;
         ri     <= ri_n;
         rq     <= rq_n;
         rto    <= rto_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      dq_n    = dq;
      done_n  = 1'b0;
      ri_n    = ri;
      rq_n    = rq;
      rto_n   = rto;
      dq_sum  = {1'b0, dq} + STEP_EXT;

      // Abort outranks convergence, timeout and handshake alike.
      if (state != S_IDLE && abort) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state_n = S_RESET_CTRL;
                  idx_n   = '0;
                  dq_n    = Q_START_SAT;
               end
            end
            S_RESET_CTRL: begin
               state_n = S_SETTLE;
               cnt_n   = '0;
            end
            S_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  state_n = S_RUN;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            S_RUN: begin
               if (ctrl_converged || cnt == TIMEOUT_LAST) begin
                  state_n = S_REPORT;
                  ri_n    = ctrl_i_ref;
                  rq_n    = measured_q;
                  rto_n   = !ctrl_converged;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            S_REPORT: begin
               if (res.result_ready) begin
                  if (idx == LAST_IDX) begin
                     state_n = S_IDLE;
                     done_n  = 1'b1;
                  end else begin
                     state_n = S_RESET_CTRL;
                     idx_n   = idx + 1'b1;
                     dq_n    = dq_sum[WIDTH] ? '1 : dq_sum[WIDTH-1:0];
                  end
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   assign busy               = (state != S_IDLE);
   assign done               = done_r;
   assign ctrl_rst           = (state == S_IDLE) || (state == S_RESET_CTRL);
   assign ctrl_ready         = (state == S_RUN);
   assign desired_q          = dq;
   assign res.result_valid   = (state == S_REPORT);
   assign res.result_i_ref   = ri;
   assign res.result_q       = rq;
   assign res.result_index   = idx;
   assign res.result_timeout = rto;

endmodule

// File: tb/tb_q_sweep_sequencer.sv
module tb_q_sweep_sequencer;

   localparam int TMO = 64;
   localparam int STL = 2;

   typedef struct {
      logic [9:0] i_ref;
      logic [9:0] q;
      logic [3:0] idx;
      logic       to;
   } res_t;

   logic       clk = 1'b0;
   logic       rst, start, abort, conv;
   logic [9:0] i_ref, mq;
   logic       busy, done, ctrl_rst, ctrl_ready;
   logic [9:0] dq;

   logic       start_b, abort_b, conv_b;
   logic       busy_b, done_b, ctrl_rst_b, ctrl_ready_b;
   logic [9:0] dq_b;

   int n_chk = 0;
   int n_fail = 0;
   res_t sb[$];
   int   qb[$];

   q_sweep_sequencer_if #(.WIDTH(10), .IDX_W(4)) ra ();
   q_sweep_sequencer_if #(.WIDTH(10), .IDX_W(2)) rb ();

   q_sweep_sequencer #(.WIDTH(10), .N_POINTS(14), .Q_START(30), .Q_STEP(20),
                       .SETTLE(STL), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .ctrl_rst(ctrl_rst), .ctrl_ready(ctrl_ready), .desired_q(dq),
      .ctrl_converged(conv), .ctrl_i_ref(i_ref), .measured_q(mq), .res(ra)
   );

   q_sweep_sequencer #(.WIDTH(10), .N_POINTS(3), .Q_START(1000), .Q_STEP(20),
                       .SETTLE(STL), .TIMEOUT(TMO)) dut_sat (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
      .ctrl_rst(ctrl_rst_b), .ctrl_ready(ctrl_ready_b), .desired_q(dq_b),
      .ctrl_converged(conv_b), .ctrl_i_ref(i_ref), .measured_q(mq), .res(rb)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] plant(input logic [9:0] i);
      return 10'((int'(i) * 3 + 17) % 1024);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ctrl_rst", ctrl_rst, 1);
      chk("rst_ctrl_ready", ctrl_ready, 0);
      chk("rst_desired_q", dq, 30);
      chk("rst_valid", ra.result_valid, 0);
      chk("rst_i_ref", ra.result_i_ref, 0);
      chk("rst_q", ra.result_q, 0);
      chk("rst_index", ra.result_index, 0);
      chk("rst_timeout", ra.result_timeout, 0);
      chk("rst_sat_desired_q", dq_b, 1000);
   endtask

   // Entered in the RESET_CTRL cycle of point idx. conv_at: RUN cycle (1-based)
   // with converged high, 0 = never. abort_at: RUN cycle to abort in, 0 = never.
   task automatic run_point(input int idx, input int conv_at, input int abort_at);
      int   w;
      bit   fin;
      res_t e;
      chk("desired_q", dq, 30 + 20 * idx);
      chk("ctrl_rst_in_reset", ctrl_rst, 1);
      chk("ready_in_reset", ctrl_ready, 0);
      w = 0;
      while (!ctrl_ready && w < 10) begin
         tick();
         w++;
      end
      chk("ready_latency", w, STL + 1);
      fin = 1'b0;
      for (int r = 1; r <= TMO && !fin; r++) begin
         i_ref = 10'(idx * 40 + r);
         mq    = plant(i_ref);
         conv  = (r == conv_at);
         if (r == abort_at) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            conv  = 1'b0;
            return;
         end
         if (conv || r == TMO) begin
            e.i_ref = i_ref;
            e.q     = mq;
            e.idx   = 4'(idx);
            e.to    = !conv;
            sb.push_back(e);
            fin = 1'b1;
         end
         tick();
         conv = 1'b0;
         if (!fin) chk("still_run", ctrl_ready, 1);
      end
      chk("report_valid", ra.result_valid, 1);
      chk("report_ready_low", ctrl_ready, 0);
   endtask

   task automatic take_result(input int hold, input bit last, input bit start_on_done);
      res_t e;
      i_ref = '0;
      mq    = '0;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", sb.size(), 1);
         return;
      end
      e = sb.pop_front();
      ra.result_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         chk("bp_valid", ra.result_valid, 1);
         chk("bp_ctrl_ready", ctrl_ready, 0);
         chk("bp_index", ra.result_index, e.idx);
         chk("bp_i_ref", ra.result_i_ref, e.i_ref);
         tick();
      end
      chk("res_valid", ra.result_valid, 1);
      chk("res_i_ref", ra.result_i_ref, e.i_ref);
      chk("res_q", ra.result_q, e.q);
      chk("res_index", ra.result_index, e.idx);
      chk("res_timeout", ra.result_timeout, e.to);
      ra.result_ready = 1'b1;
      start = start_on_done;
      tick();
      ra.result_ready = 1'b0;
      start = 1'b0;
      if (last) begin
         chk("done_pulse", done, 1);
         chk("done_busy", busy, 0);
         chk("done_ctrl_rst", ctrl_rst, 1);
         tick();
         chk("done_one_cycle", done, 0);
         chk("start_on_done_ignored", busy, 0);
      end else begin
         chk("valid_dropped", ra.result_valid, 0);
         chk("no_done", done, 0);
         chk("busy_between", busy, 1);
      end
   endtask

   task automatic check_aborted();
      chk("abort_ctrl_rst", ctrl_rst, 1);
      chk("abort_ctrl_ready", ctrl_ready, 0);
      chk("abort_busy", busy, 0);
      chk("abort_valid", ra.result_valid, 0);
      chk("abort_no_done", done, 0);
      tick();
      chk("abort_no_done_later", done, 0);
      chk("abort_stays_idle", busy, 0);
   endtask

   initial begin
      int ca;
      int nidx;
      bit seen_done;
      rst = 1'b1; start = 1'b0; abort = 1'b0; conv = 1'b0;
      i_ref = '0; mq = '0; ra.result_ready = 1'b0;
      start_b = 1'b0; abort_b = 1'b0; conv_b = 1'b1; rb.result_ready = 1'b1;
      tick();
      tick();
      check_reset();
      rst = 1'b0;
      tick();
      chk("idle_abort_ignored_busy", busy, 0);

      // Full sweep: varied convergence, coincidence, timeouts, backpressure.
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", busy, 1);
      for (int p = 0; p < 14; p++) begin
         if (p == 6)                ca = TMO;
         else if (p == 7 || p == 8) ca = 0;
         else                       ca = 1 + (p * 7) % 20;
         run_point(p, ca, 0);
         take_result((p == 3) ? 10 : 0, p == 13, p == 13);
      end

      // Abort in RUN of point 5, together with convergence.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int p = 0; p < 5; p++) begin
         run_point(p, 2 + p, 0);
         take_result(0, 1'b0, 1'b0);
      end
      run_point(5, 3, 3);
      check_aborted();

      // Abort in REPORT while the result is held off.
      start = 1'b1;
      tick();
      start = 1'b0;
      run_point(0, 4, 0);
      ra.result_ready = 1'b0;
      tick();
      tick();
      chk("held_valid", ra.result_valid, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      sb.delete();
      check_aborted();

      // Restart from index 0, then reset during SETTLE of point 1.
      start = 1'b1;
      tick();
      start = 1'b0;
      run_point(0, 0, 0);
      take_result(0, 1'b0, 1'b0);
      chk("next_desired_q", dq, 50);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset();

      // Saturating setpoints on the second instance.
      qb.push_back(1000);
      qb.push_back(1020 > 1023 ? 1023 : 1020);
      qb.push_back(1040 > 1023 ? 1023 : 1040);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      nidx = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 60 && !seen_done; c++) begin
         if (ctrl_ready_b) begin
            if (qb.size() == 0) chk("sat_extra_run", 0, 1);
            else                chk("sat_desired_q", dq_b, qb.pop_front());
         end
         if (rb.result_valid) begin
            chk("sat_index", rb.result_index, nidx);
            nidx++;
         end
         if (done_b) seen_done = 1'b1;
         tick();
      end
      chk("sat_done_seen", seen_done, 1);
      chk("sat_points_left", qb.size(), 0);
      chk("sat_results", nidx, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/q_sweep_sequencer.md
Name: q_sweep_sequencer

Overview:
Sequences the bisection/secant i_ref controller through a programmed sweep of desired_q setpoints.
- For each point it resets the controller, presents the setpoint and enables it.
- It then waits for convergence or a timeout, and reports the final i_ref/measured_q pair on a valid/ready result stream.
- It sits between the top-level test/calibration logic and the controller, replacing manual per-setpoint reset and reload.

Parameters:
WIDTH, 10, width of desired_q, measured_q and i_ref
N_POINTS, 14, number of setpoints in one sweep (>=1)
Q_START, 30, first setpoint
Q_STEP, 20, increment between consecutive setpoints
SETTLE, 2, cycles the controller is held with ctrl_ready=0 after its reset (>=1)
TIMEOUT, 64, max cycles in RUN before a point is abandoned (>=2)
IDX_W, $clog2(N_POINTS) (min 1), width of result_index

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  terminate sweep; sampled in every non-IDLE state
busy  out  1  high from the cycle after start is accepted until return to IDLE
done  out  1  one-cycle pulse when the last result handshake completes
ctrl_rst  out  1  drives controller rst
ctrl_ready  out  1  drives controller ready/enable
desired_q  out  WIDTH  current setpoint to the controller
ctrl_converged  in  1  controller converged flag
ctrl_i_ref  in  WIDTH  controller i_ref
measured_q  in  WIDTH  plant Q measurement
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_i_ref  out  WIDTH  captured i_ref
result_q  out  WIDTH  captured measured_q
result_index  out  IDX_W  setpoint index of result
result_timeout  out  1  point ended by timeout, not convergence

Behaviour:
- Reset values:
  - busy=0, done=0, ctrl_rst=1, ctrl_ready=0.
  - desired_q=Q_START, result_valid=0, result_i_ref/result_q/result_index/result_timeout=0.
  - Internal state: state=IDLE, idx=0, counters=0.
- ctrl_rst is high in IDLE and RESET_CTRL, and low elsewhere. ctrl_ready is high only in RUN.
- IDLE:
  - start=1 -> RESET_CTRL, busy=1, idx=0, desired_q=Q_START.
  - abort is ignored in IDLE.
- RESET_CTRL: one cycle, then -> SETTLE with the settle counter cleared.
- SETTLE:
  - Lasts exactly SETTLE cycles, then -> RUN with the timeout counter cleared.
  - Start sampled at edge k gives ctrl_ready=1 first at cycle k+2+SETTLE.
- RUN, per cycle:
  - ctrl_converged=1: capture ctrl_i_ref and measured_q, set result_timeout=0 -> REPORT.
  - Otherwise, if the timeout counter == TIMEOUT-1: capture the same signals, set result_timeout=1 -> REPORT.
  - Converged and timeout in the same cycle: converged wins.
- REPORT:
  - result_valid=1; data and index are stable while valid && !ready.
  - On a handshake (result_valid && result_ready):
    - If idx==N_POINTS-1: -> IDLE, done=1 for one cycle, busy=0.
    - Else: idx+1, desired_q = desired_q + Q_STEP -> RESET_CTRL.
  - result_valid drops the cycle after the handshake.
- Setpoint arithmetic:
  - Computed in WIDTH+1 bits and saturated to 2^WIDTH-1; never wraps.
  - Q_START is also saturated.
- Abort (any non-IDLE state):
  - Next cycle -> IDLE: ctrl_rst=1, ctrl_ready=0, busy=0, result_valid=0.
  - No done pulse.
  - A pending unaccepted result is discarded.
  - Abort has priority over convergence, timeout and handshake in the same cycle.
- Start in the same cycle as the done/IDLE return: not accepted. It is sampled only when state==IDLE at the edge.
- rst mid-operation: all registers return to reset values on the next edge, irrespective of other inputs.
- ctrl_converged outside RUN is ignored. The controller is always freshly reset per point, so a stale converged flag cannot end a point.

Test Plan:
- Nominal sweep:
  - Stimulus: defaults, start pulse, behavioural plant model (measured_q = f(i_ref) table), controller converges within 20 cycles, result_ready=1.
  - Required response: 14 results, index 0..13, desired_q 30,50,...,290, result_timeout=0, then one done pulse and busy=0.
- Timeout:
  - Stimulus: ctrl_converged held 0.
  - Required response: each point reports after exactly TIMEOUT=64 RUN cycles with result_timeout=1, result_i_ref equal to ctrl_i_ref at the final RUN cycle, and the sweep continues.
- Backpressure:
  - Stimulus: result_ready=0 for 10 cycles on point 3.
  - Required response: result_valid held, fields stable, ctrl_ready=0, no advance; index 4 starts RESET_CTRL the cycle after the handshake.
- Abort:
  - Stimulus: abort during RUN of point 5; abort during REPORT with ready=0.
  - Required response: next cycle IDLE, ctrl_rst=1, result_valid=0, no done; a new start restarts at index 0, desired_q=30.
- Saturation/reset:
  - Stimulus: Q_START=1000, Q_STEP=20, N_POINTS=3.
  - Required response: desired_q 1000,1020,1023.
  - Stimulus: rst pulsed during SETTLE.
  - Required response: all outputs at reset values next cycle.
- Timing corners:
  - ctrl_ready first high at start-edge+2+SETTLE.
  - ctrl_converged and timeout coincide -> result_timeout=0.
  - start asserted on the done cycle is ignored.
